// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types and constants for the alu_share_arb block
//
// Contents:
//   ALU_OP_00..ALU_OP_11 : 2-bit opcodes understood by the shared ALU
//                          00 add, 01 subtract (a - b), 10 bitwise and, 11 bitwise xor
//   FLG_*                : bit positions inside the 5-bit flag vector
//                          {parity, overflow, greater, is_eq, less}
//   state_t              : sequencer states IDLE / EXEC / RESP
package alu_share_pkg;

    localparam logic [1:0] ALU_OP_00 = 2'b00;
    localparam logic [1:0] ALU_OP_01 = 2'b01;
    localparam logic [1:0] ALU_OP_10 = 2'b10;
    localparam logic [1:0] ALU_OP_11 = 2'b11;

    localparam int FLG_PARITY = 4;
    localparam int FLG_OVF    = 3;
    localparam int FLG_GT     = 2;
    localparam int FLG_EQ     = 1;
    localparam int FLG_LT     = 0;
    localparam int FLG_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_alu.sv
// rtl/alu_share_alu.sv - combinational 8-bit ALU shared by all requesters
//
// Ports:
//   a, b  in  8 : operands
//   op    in  2 : opcode (ALU_OP_* in alu_share_pkg)
//   y     out 8 : result
//   flags out 5 : {parity, overflow, greater, is_eq, less}
//                 parity   = XOR of all bits of y
//                 overflow = signed overflow for add/sub, 0 for logic ops
//                 greater/is_eq/less = unsigned compare of a against b
module alu_share_alu
    import alu_share_pkg::*;
(
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [1:0]       op,
    output logic [7:0]       y,
    output logic [FLG_W-1:0] flags
);

    logic ovf;

    always_comb begin
        y   = 8'h00;
        ovf = 1'b0;
        case (op)
            ALU_OP_00: begin
                y   = a + b;
                // operands of equal sign producing a result of the other sign
                ovf = (a[7] == b[7]) && (y[7] != a[7]);
            end
            ALU_OP_01: begin
                y   = a - b;
                ovf = (a[7] != b[7]) && (y[7] != a[7]);
            end
            ALU_OP_10: y = a & b;
            ALU_OP_11: y = a ^ b;
            default: ;
        endcase

        flags             = '0;
        flags[FLG_PARITY] = ^y;
        flags[FLG_OVF]    = ovf;
        flags[FLG_GT]     = a > b;
        flags[FLG_EQ]     = a == b;
        flags[FLG_LT]     = a < b;
    end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter
//
// Ports:
//   req     in  N : request vector
//   last    in  W : index of the most recent grantee; search starts at last+1
//   gnt     out N : one-hot grant (all zero when no request)
//   gnt_idx out W : encoded grant index (0 when no request)
module rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    int           cand;
    logic [W-1:0] cand_idx;
    logic         found;

    // Walk last+1 .. last+N modulo N; the first set request wins.
    // Offset N wraps back to last itself, so a lone requester is always
    // re-granted with no fairness gap.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= N; i++) begin
            cand = int'(last) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = W'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sequencer sharing one ALU among N_REQ requesters
//
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/req_ready    : per-requester handshake (ready only on the grantee)
//   req_a, req_b, req_op   : packed operands, requester i at [8i+7:8i] / [2i+1:2i]
//   rsp_valid/rsp_ready    : single response channel handshake
//   rsp_id, rsp_y, rsp_flags : registered tag, result and flags
//   op_count               : completed responses, wraps at 16 bits
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    input  logic [2*N_REQ-1:0] req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [7:0]         rsp_y,
    output logic [FLG_W-1:0]   rsp_flags,
    output logic [15:0]        op_count
);

    state_t           state_q;
    state_t           state_d;
    logic [ID_W-1:0]  last_q;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             any_req;
    logic             grant_en;
    logic             grant_fire;
    logic             rsp_fire;

    logic [7:0]       sel_a;
    logic [7:0]       sel_b;
    logic [1:0]       sel_op;

    logic [7:0]       op_a_q;
    logic [7:0]       op_b_q;
    logic [1:0]       op_op_q;
    logic [ID_W-1:0]  op_id_q;

    logic [7:0]       alu_y;
    logic [FLG_W-1:0] alu_flags;
    logic [15:0]      cnt_q;

    assign any_req  = |req_valid;
    assign op_count = cnt_q;

    rr_arb #(
        .N (N_REQ),
        .W (ID_W)
    ) u_rr_arb (
        .req     (req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The ALU only ever sees the operand register, so rsp_* never has a
    // combinational path back to the request ports.
    alu_share_alu u_alu (
        .a     (op_a_q),
        .b     (op_b_q),
        .op    (op_op_q),
        .y     (alu_y),
        .flags (alu_flags)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = any_req ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: a grant may fire from IDLE, or from RESP in the same
    // cycle the response is taken (back-to-back issue).
    always_comb begin
        grant_en   = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        req_ready  = grant_en ? gnt : '0;
        grant_fire = grant_en && any_req;
        rsp_fire   = (state_q == RESP) && rsp_ready;
    end

    // One-hot operand select from the packed request buses
    always_comb begin
        sel_a  = 8'h00;
        sel_b  = 8'h00;
        sel_op = 2'b00;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[8*i +: 8];
                sel_b  = req_b[8*i +: 8];
                sel_op = req_op[2*i +: 2];
            end
        end
    end

    // Operand register and round-robin pointer, updated on grant fire only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_q  <= 8'h00;
            op_b_q  <= 8'h00;
            op_op_q <= 2'b00;
            op_id_q <= '0;
            last_q  <= ID_W'(N_REQ - 1);
        end else if (grant_fire) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            op_op_q <= sel_op;
            op_id_q <= gnt_idx;
            last_q  <= gnt_idx;
        end
    end

    // Result register and completion counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= 8'h00;
            rsp_flags <= '0;
            cnt_q     <= 16'h0000;
        end else begin
            rsp_valid <= (state_d == RESP);
            if (state_q == EXEC) begin
                rsp_y     <= alu_y;
                rsp_flags <= alu_flags;
                rsp_id    <= op_id_q;
            end
            if (rsp_fire) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb
module tb_alu_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_y;
    logic [4:0]  rsp_flags;
    logic [15:0] op_count;

    logic [15:0] rsp_vec;
    assign rsp_vec = {rsp_valid, rsp_id, rsp_y, rsp_flags};

    int checks;
    int failures;

    // Hand-computed ALU results for the fixed operands of each requester
    // r0: 05 + 03      -> 08, parity 1, gt          -> 10100
    // r1: 70 + 20      -> 90, signed overflow, gt   -> 01100
    // r2: 3C - 3C      -> 00, eq                    -> 00010
    // r3: 0F ^ F0      -> FF, parity 0, lt          -> 00001
    logic [7:0] exp_y [4];
    logic [4:0] exp_f [4];

    alu_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_flags (rsp_flags),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'h0);
        end
        checks++;
        if (rsp_vec !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rsp got=%h exp=%h", rsp_vec, 16'h0000);
        end
        checks++;
        if (op_count !== 16'h0000) begin
            failures++;
            $display("FAIL reset_count got=%h exp=%h", op_count, 16'h0000);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0001);
        end
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 5'b0) begin
            failures++;
            $display("FAIL single_exec got=%b exp=%b", {req_ready, rsp_valid}, 5'b0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_vec !== {1'b1, 2'd0, 8'h08, 5'b10100}) begin
            failures++;
            $display("FAIL single_rsp got=%h exp=%h", rsp_vec, {1'b1, 2'd0, 8'h08, 5'b10100});
        end
        checks++;
        if (op_count !== 16'd0) begin
            failures++;
            $display("FAIL single_count_pre got=%h exp=%h", op_count, 16'd0);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, op_count} !== {1'b0, 16'd1}) begin
            failures++;
            $display("FAIL single_done got=%h exp=%h", {rsp_valid, op_count}, {1'b0, 16'd1});
        end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_rdy;
        logic [15:0] exp_vec;
        int          id;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            req_valid = (k <= 10) ? 4'hF : 4'h0;
            #1;
            exp_rdy = ((k % 2 == 0) && (k <= 10)) ? 4'(1 << ((k / 2) % 4)) : 4'h0;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy);
            end
            if ((k % 2 == 0) && (k >= 2) && (k <= 12)) begin
                id      = ((k / 2) - 1) % 4;
                exp_vec = {1'b1, 2'(id), exp_y[id], exp_f[id]};
                checks++;
                if (rsp_vec !== exp_vec) begin
                    failures++;
                    $display("FAIL rr_rsp k=%0d got=%h exp=%h", k, rsp_vec, exp_vec);
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_gap k=%0d got=%b exp=%b", k, rsp_valid, 1'b0);
                end
            end
        end
        checks++;
        if (op_count !== 16'd6) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=%0d", op_count, 6);
        end
    endtask

    task automatic test_skip;
        int          ord [3];
        logic [3:0]  exp_rdy;
        logic [15:0] exp_vec;
        int          id;
        ord = '{3, 1, 3};
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            req_valid = (k <= 4) ? 4'b1010 : 4'h0;
            #1;
            exp_rdy = ((k % 2 == 0) && (k <= 4)) ? 4'(1 << ord[k / 2]) : 4'h0;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL skip_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy);
            end
            if ((k % 2 == 0) && (k >= 2) && (k <= 6)) begin
                id      = ord[(k / 2) - 1];
                exp_vec = {1'b1, 2'(id), exp_y[id], exp_f[id]};
                checks++;
                if (rsp_vec !== exp_vec) begin
                    failures++;
                    $display("FAIL skip_rsp k=%0d got=%h exp=%h", k, rsp_vec, exp_vec);
                end
            end
        end
        checks++;
        if (op_count !== 16'd9) begin
            failures++;
            $display("FAIL skip_count got=%0d exp=%0d", op_count, 9);
        end
    endtask

    task automatic test_back_pressure;
        logic [15:0] r0_vec;
        logic [15:0] r1_vec;
        r0_vec = {1'b1, 2'd0, 8'h08, 5'b10100};
        r1_vec = {1'b1, 2'd1, 8'h90, 5'b01100};
        @(negedge clk);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=%b", req_ready, 4'b0001);
        end
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 5'b0) begin
            failures++;
            $display("FAIL bp_exec got=%b exp=%b", {req_ready, rsp_valid}, 5'b0);
        end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({req_ready, rsp_vec} !== {4'h0, r0_vec}) begin
                failures++;
                $display("FAIL bp_hold k=%0d got=%h exp=%h", k, {req_ready, rsp_vec}, {4'h0, r0_vec});
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_vec} !== {4'b0010, r0_vec}) begin
            failures++;
            $display("FAIL bp_release got=%h exp=%h", {req_ready, rsp_vec}, {4'b0010, r0_vec});
        end
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 5'b0) begin
            failures++;
            $display("FAIL bp_exec2 got=%b exp=%b", {req_ready, rsp_valid}, 5'b0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_vec !== r1_vec) begin
            failures++;
            $display("FAIL bp_rsp2 got=%h exp=%h", rsp_vec, r1_vec);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, op_count} !== {1'b0, 16'd11}) begin
            failures++;
            $display("FAIL bp_count got=%h exp=%h", {rsp_valid, op_count}, {1'b0, 16'd11});
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL mid_grant got=%b exp=%b", req_ready, 4'b0100);
        end
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_vec, op_count} !== 36'h0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", {req_ready, rsp_vec, op_count}, 36'h0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_rsp got=%b exp=%b", rsp_valid, 1'b0);
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_prio got=%b exp=%b", req_ready, 4'b0001);
        end
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_vec !== {1'b1, 2'd0, 8'h08, 5'b10100}) begin
            failures++;
            $display("FAIL mid_rsp got=%h exp=%h", rsp_vec, {1'b1, 2'd0, 8'h08, 5'b10100});
        end
        @(negedge clk);
        #1;
        checks++;
        if (op_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_count got=%0d exp=%0d", op_count, 1);
        end
    endtask

    task automatic test_count_wrap;
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        #1;
        checks++;
        if (op_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_preload got=%h exp=%h", op_count, 16'hFFFE);
        end
        // requester 2 switched to AND: 3C & 3C -> 3C, parity 0, eq
        req_op[5:4] = 2'b10;
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_grant1 got=%b exp=%b", req_ready, 4'b0100);
        end
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_vec !== {1'b1, 2'd2, 8'h3C, 5'b00010}) begin
            failures++;
            $display("FAIL wrap_rsp1 got=%h exp=%h", rsp_vec, {1'b1, 2'd2, 8'h3C, 5'b00010});
        end
        @(negedge clk);
        #1;
        checks++;
        if (op_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_ffff got=%h exp=%h", op_count, 16'hFFFF);
        end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL wrap_grant2 got=%b exp=%b", req_ready, 4'b0010);
        end
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_vec !== {1'b1, 2'd1, 8'h90, 5'b01100}) begin
            failures++;
            $display("FAIL wrap_rsp2 got=%h exp=%h", rsp_vec, {1'b1, 2'd1, 8'h90, 5'b01100});
        end
        @(negedge clk);
        #1;
        checks++;
        if (op_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=%h", op_count, 16'h0000);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_y    = '{8'h08, 8'h90, 8'h00, 8'hFF};
        exp_f    = '{5'b10100, 5'b01100, 5'b00010, 5'b00001};
        req_a    = {8'h0F, 8'h3C, 8'h70, 8'h05};
        req_b    = {8'hF0, 8'h3C, 8'h20, 8'h03};
        req_op   = {2'b11, 2'b01, 2'b00, 2'b00};

        test_reset();
        test_single();
        test_round_robin();
        test_skip();
        test_back_pressure();
        test_reset_mid();
        test_count_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one 8-bit ALU datapath among `N_REQ` requesters. The shared datapath takes operands `a`, `b`, `op[1:0]`. It returns `y[7:0]` and the flags `parity`, `overflow`, `greater`, `is_eq`, `less`. The block sits between requester ports with a valid/ready handshake and that combinational ALU. It registers the operands, evaluates them, and returns a tagged, registered result on a single response channel.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default $clog2(N_REQ): width of the requester tag.
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `req_valid`  in  N_REQ  — per-requester request valid.
- `req_ready`  out  N_REQ  — per-requester accept; high on the granted requester only.
- `req_a`  in  8*N_REQ  — operand a; requester i occupies bits [8i+7:8i].
- `req_b`  in  8*N_REQ  — operand b, packed the same way as `req_a`.
- `req_op`  in  2*N_REQ  — opcode; requester i occupies bits [2i+1:2i].
- `rsp_valid`  out  1  — result valid.
- `rsp_ready`  in  1  — consumer accepts the result.
- `rsp_id`  out  ID_W  — index of the requester that owns the result.
- `rsp_y`  out  8  — ALU `y`.
- `rsp_flags`  out  5  — {parity, overflow, greater, is_eq, less}.
- `op_count`  out  16  — number of completed responses; wraps.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, grant one requester and assert its `req_ready` in that cycle (fire).
  - Latch its a/b/op/id into the operand register; next state is EXEC.
- EXEC:
  - The shared ALU evaluates the operand register combinationally.
  - At the end of the cycle, y and flags go into the result register; next state is RESP.
  - All `req_ready` are low.
- RESP:
  - `rsp_valid` is 1.
  - If `rsp_ready` is high and any `req_valid` is high, the response fires and a new grant fires in the same cycle; next state is EXEC (back-to-back).
  - If `rsp_ready` is high and no request is pending, next state is IDLE.
  - If `rsp_ready` is low, hold: `req_ready` stays 0 and the result and `rsp_id` stay stable.
- Arbitration:
  - Round-robin using pointer `last`, the index of the most recent grantee.
  - Search order is last+1, last+2, … modulo N_REQ.
  - `last` updates only on a grant fire.
- `req_ready` is combinational from `req_valid`, state and `last`. It never depends on `req_valid` of the same requester toggling within the cycle.
- A requester must hold a/b/op stable while valid and not ready. The block samples them only on fire.
- `op_count` increments by 1 on each response fire and wraps from 16'hFFFF to 0.
- The ALU is opaque: `op` is passed through unmodified, and its encoding is defined in the package.

## Timing
- Reset values:
  - state is IDLE; `last` is N_REQ-1, so requester 0 has top priority after reset.
  - `rsp_valid`, `rsp_id`, `rsp_y`, `rsp_flags`, `op_count` are 0; `req_ready` is 0.
- Latency: a request fired at cycle T gives `rsp_valid`=1 at T+2.
- Throughput: one operation per 2 cycles when `rsp_ready` is held high.
- Reset asserted mid-operation drops the in-flight operation and result. No response is issued for it.
- A single requester valid every cycle is granted every opportunity; no fairness stall is inserted.
- `rsp_*` outputs come from registers only, with no combinational path from `req_*`.

## Structure
- Package `alu_share_pkg`:
  - opcode constants `ALU_OP_00..ALU_OP_11` (2-bit);
  - flag bit indices `FLG_PARITY=4, FLG_OVF=3, FLG_GT=2, FLG_EQ=1, FLG_LT=0`;
  - state enum {IDLE, EXEC, RESP}.
- Sub-module `rr_arb #(N)`: inputs `req`, `last`; outputs one-hot `gnt` and encoded `gnt_idx`. It is purely combinational.
- The shared ALU is instantiated once inside the block. It is fed only from the operand register.

## Test plan
- Reset, then requester 0 valid with a=8'h05, b=8'h03, op=2'b00 → `req_ready[0]` is high the same cycle; `rsp_valid` at +2 with `rsp_id`=0; y and flags equal the ALU golden model; `op_count`=1.
- All four requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0,1; one response every 2 cycles; ids in the same order.
- Only requesters 1 and 3 valid, with `last`=1 → 3 is granted next, then 1. Requesters 0 and 2 never get `req_ready`.
- `rsp_ready` held low for 5 cycles during RESP → `rsp_*` stable and all `req_ready`=0; on release, the next grant fires in the same cycle and its response appears 2 cycles later.
- `rst_n` driven low for 1 cycle while in EXEC → all outputs return to reset values next cycle, no response for the dropped operation, and the next grant goes to requester 0.
- Preload `op_count` to 16'hFFFE via 65534 responses (or force), then 2 more responses → `op_count` reads 16'hFFFF then 16'h0000.
